// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage byte-serial access sequencer.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    GAP,
    RESP
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned KERNEL_BASE    = 0;
  localparam int unsigned IMAGE_BASE     = 100;
  localparam int unsigned IMAGE_SIZE     = 2500;

endpackage

// File: rtl/mem_access_unit.sv
// MEM-stage access sequencer: splits a byte/word load or store into single-byte
// accesses to an edge-triggered byte memory, one enable pulse per byte with an
// idle GAP cycle between pulses. Holds the pipeline via busy until done.
// Optional access-fault check (alignment / range) enabled by MEM_ACCESS_FAULT_EN.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int N          = 32,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 8192
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic         req_byte,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         busy,
  output logic         resp_valid,
  output logic [N-1:0] resp_rdata,
  output logic         resp_fault,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  output logic         mem_read_en,
  output logic         mem_write_en
);

  state_t       state_q, state_d;
  logic         write_q, write_d;
  logic         byte_q, byte_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic [1:0]   idx_q, idx_d;
  logic [1:0]   last_q, last_d;
  logic [N-1:0] buf_q, buf_d;
  logic [N-1:0] mem_addr_d, mem_wdata_d, resp_rdata_d;
  logic         read_en_d, write_en_d, resp_valid_d;
  logic         fault_q, fault_d;
  logic         acc_fault;
  logic         unused_bits;

`ifdef MEM_ACCESS_FAULT_EN
  // Fault check on the incoming request: unaligned word or last byte past the end
  always_comb begin
    acc_fault = (!req_byte && (req_addr[1:0] != 2'b00)) ||
                (({1'b0, req_addr} + (N+1)'(req_byte ? 0 : BYTES_PER_WORD - 1))
                 >= (N+1)'(MEM_DEPTH));
  end
  assign unused_bits = &{1'b0, mem_rdata[N-1:DATA_WIDTH]};
`else
  assign acc_fault   = 1'b0;
  assign unused_bits = &{1'b0, mem_rdata[N-1:DATA_WIDTH], (MEM_DEPTH > 0)};
`endif

  assign busy       = (state_q != IDLE);
  assign req_ready  = (state_q == IDLE);
  assign resp_fault = fault_q;

  // Next-state and next-output logic; outputs are derived from the next state
  // so that every memory/response signal leaves the unit straight from a flop.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    byte_d       = byte_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    idx_d        = idx_q;
    last_d       = last_q;
    buf_d        = buf_q;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    resp_rdata_d = resp_rdata;
    read_en_d    = 1'b0;
    write_en_d   = 1'b0;
    fault_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          byte_d  = req_byte;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          last_d  = req_byte ? 2'd0 : 2'(BYTES_PER_WORD - 1);
          idx_d   = '0;
          buf_d   = '0;
          if (acc_fault) begin
            state_d = RESP;
            fault_d = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: state_d = GAP;
      GAP: begin
        if (!write_q)
          buf_d[32'(idx_q) * DATA_WIDTH +: DATA_WIDTH] = mem_rdata[DATA_WIDTH-1:0];
        if (idx_q == last_q) begin
          state_d = RESP;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ACCESS;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Entering ACCESS (from IDLE or GAP) launches one byte access.
    if (state_d == ACCESS) begin
      mem_addr_d = addr_d + N'(idx_d);
      if (write_d) begin
        mem_wdata_d = N'(wdata_d[32'(idx_d) * DATA_WIDTH +: DATA_WIDTH]);
        write_en_d  = 1'b1;
      end else begin
        read_en_d = 1'b1;
      end
    end

    resp_valid_d = (state_d == RESP);
    if (state_d == RESP)
      resp_rdata_d = write_d ? '0 : buf_d;
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      byte_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      idx_q        <= '0;
      last_q       <= '0;
      buf_q        <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      byte_q       <= byte_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      buf_q        <= buf_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      mem_read_en  <= read_en_d;
      mem_write_en <= write_en_d;
      resp_valid   <= resp_valid_d;
      resp_rdata   <= resp_rdata_d;
      fault_q      <= fault_d;
    end
  end

endmodule
